// File: rtl/mem_cmd_gen.sv
// Memory command generator: walks the transaction count, pulls addresses from the
// address generator and issues Avalon-MM write/read commands toward the memory under test.
module mem_cmd_gen #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              test_start_i,
    input  logic [1:0]        test_mode_i,
    input  logic [31:0]       trans_cnt_i,
    input  logic [7:0]        data_pattern_i,
    input  logic [ADDR_W-1:0] next_addr_i,
    output logic              next_addr_en_o,
    output logic [ADDR_W-1:0] amm_address_o,
    output logic              amm_write_o,
    output logic              amm_read_o,
    output logic [DATA_W-1:0] amm_writedata_o,
    input  logic              amm_waitrequest_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CMD,
        S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_mode, w_mode_nxt;
    logic [31:0]         r_cnt, w_cnt_nxt;
    logic [7:0]          r_pattern, w_pattern_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic                r_write, w_write_nxt;
    logic                r_read, w_read_nxt;
    logic                r_wphase, w_wphase_nxt;
    logic                w_accept;
    logic                w_advance;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_mode    <= 2'd0;
            r_cnt     <= 32'd0;
            r_pattern <= 8'd0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_read    <= 1'b0;
            r_wphase  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pattern <= w_pattern_nxt;
            r_addr    <= w_addr_nxt;
            r_write   <= w_write_nxt;
            r_read    <= w_read_nxt;
            r_wphase  <= w_wphase_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_cnt_nxt     = r_cnt;
        w_pattern_nxt = r_pattern;
        w_addr_nxt    = r_addr;
        w_write_nxt   = r_write;
        w_read_nxt    = r_read;
        w_wphase_nxt  = r_wphase;
        w_advance     = 1'b0;
        w_accept      = (r_write | r_read) & ~amm_waitrequest_i;

        case (r_state)
            S_IDLE: begin
                if (test_start_i) begin
                    w_mode_nxt    = test_mode_i;
                    w_cnt_nxt     = trans_cnt_i;
                    w_pattern_nxt = data_pattern_i;
                    w_state_nxt   = (trans_cnt_i == 32'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                // Reserved mode 3 falls into the read path through mode bit 0.
                w_addr_nxt   = next_addr_i;
                w_write_nxt  = (r_mode == 2'd0) || (r_mode == 2'd2);
                w_read_nxt   = r_mode[0];
                w_wphase_nxt = (r_mode == 2'd2);
                w_state_nxt  = S_CMD;
            end
            S_CMD: begin
                if (w_accept) begin
                    if (r_wphase) begin
                        w_write_nxt  = 1'b0;
                        w_read_nxt   = 1'b1;
                        w_wphase_nxt = 1'b0;
                    end else begin
                        w_advance   = 1'b1;
                        w_cnt_nxt   = (r_cnt != 32'd0) ? r_cnt - 32'd1 : r_cnt;
                        w_write_nxt = 1'b0;
                        w_read_nxt  = 1'b0;
                        w_state_nxt = (r_cnt == 32'd1) ? S_DONE : S_LOAD;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign next_addr_en_o  = w_advance;
    assign amm_address_o   = r_addr;
    assign amm_write_o     = r_write;
    assign amm_read_o      = r_read;
    assign amm_writedata_o = {(DATA_W/8){r_pattern}};
    assign busy_o          = (r_state != S_IDLE);
    assign done_o          = (r_state == S_DONE);

endmodule

// File: tb/tb_mem_cmd_gen.sv
// Bench for mem_cmd_gen: behavioural address generator, command monitor and an
// expected-command list derived from mode/count/base.
module tb_mem_cmd_gen;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              test_start_i = 1'b0;
    logic [1:0]        test_mode_i = 2'd0;
    logic [31:0]       trans_cnt_i = 32'd0;
    logic [7:0]        data_pattern_i = 8'd0;
    logic [ADDR_W-1:0] next_addr_i;
    logic              next_addr_en_o;
    logic [ADDR_W-1:0] amm_address_o;
    logic              amm_write_o;
    logic              amm_read_o;
    logic [DATA_W-1:0] amm_writedata_o;
    logic              amm_waitrequest_i = 1'b0;
    logic              busy_o;
    logic              done_o;

    mem_cmd_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .test_start_i(test_start_i),
        .test_mode_i(test_mode_i), .trans_cnt_i(trans_cnt_i),
        .data_pattern_i(data_pattern_i), .next_addr_i(next_addr_i),
        .next_addr_en_o(next_addr_en_o), .amm_address_o(amm_address_o),
        .amm_write_o(amm_write_o), .amm_read_o(amm_read_o),
        .amm_writedata_o(amm_writedata_o), .amm_waitrequest_i(amm_waitrequest_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    int n_done = 0, n_adv = 0, n_both = 0;
    int stall_pct = 0;
    bit wr_force = 1'b0;
    logic [ADDR_W-1:0] gen_base = '0;

    bit                q_w[$];
    logic [ADDR_W-1:0] q_a[$];
    logic [DATA_W-1:0] q_d[$];
    bit                e_w[$];
    logic [ADDR_W-1:0] e_a[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Address generator: loads its base on an idle start, steps on each advance strobe.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) next_addr_i <= '0;
        else if (test_start_i && !busy_o) next_addr_i <= gen_base;
        else if (next_addr_en_o) next_addr_i <= next_addr_i + 1'b1;
    end

    always @(posedge clk_i) begin
        #1;
        amm_waitrequest_i = wr_force || (stall_pct > 0 && $urandom_range(0, 99) < stall_pct);
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (amm_write_o && amm_read_o) n_both++;
            if ((amm_write_o || amm_read_o) && !amm_waitrequest_i) begin
                q_w.push_back(amm_write_o);
                q_a.push_back(amm_address_o);
                q_d.push_back(amm_writedata_o);
            end
            if (next_addr_en_o) n_adv++;
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic model_cmds(input logic [1:0] m, input int unsigned n, input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] a;
        e_w.delete();
        e_a.delete();
        for (int unsigned i = 0; i < n; i++) begin
            a = b + ADDR_W'(i);
            if (m == 2'd0 || m == 2'd2) begin e_w.push_back(1'b1); e_a.push_back(a); end
            if (m != 2'd0) begin e_w.push_back(1'b0); e_a.push_back(a); end
        end
    endtask

    function automatic int exp_latency(input logic [1:0] m, input int unsigned n);
        if (n == 0) return 1;
        return (m == 2'd2) ? 3 * int'(n) + 1 : 2 * int'(n) + 1;
    endfunction

    task automatic start_test(input logic [1:0] m, input logic [31:0] n, input logic [7:0] p,
                              input logic [ADDR_W-1:0] b);
        @(posedge clk_i); #1;
        q_w.delete(); q_a.delete(); q_d.delete();
        n_adv = 0; n_done = 0; n_both = 0;
        gen_base = b;
        test_mode_i = m; trans_cnt_i = n; data_pattern_i = p;
        test_start_i = 1'b1;
        start_cyc = cyc;
        @(posedge clk_i); #1;
        test_start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (n_done == 0 && i < budget) begin
            @(posedge clk_i);
            i++;
        end
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if ({next_addr_en_o, amm_address_o, amm_write_o, amm_read_o, amm_writedata_o, busy_o, done_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b a=%h w=%b r=%b d=%h busy=%b done=%b, want all 0",
                     next_addr_en_o, amm_address_o, amm_write_o, amm_read_o, amm_writedata_o, busy_o, done_o);
        end
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic test_write_only();
        logic [DATA_W-1:0] ed = {(DATA_W/8){8'hA5}};
        stall_pct = 0;
        model_cmds(2'd0, 3, 16'h0010);
        start_test(2'd0, 32'd3, 8'hA5, 16'h0010);
        n_chk++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL wo_busy: got %b want 1", busy_o); end
        wait_done(60);
        n_chk++;
        if (q_w.size() != e_w.size()) begin n_fail++; $display("FAIL wo_count: got %0d cmds want %0d", q_w.size(), e_w.size()); end
        for (int i = 0; i < q_w.size() && i < e_w.size(); i++) begin
            n_chk++;
            if (q_w[i] !== e_w[i] || q_a[i] !== e_a[i] || q_d[i] !== ed) begin
                n_fail++;
                $display("FAIL wo_cmd%0d: got w=%b a=%h d=%h want w=%b a=%h d=%h", i, q_w[i], q_a[i], q_d[i], e_w[i], e_a[i], ed);
            end
        end
        n_chk++;
        if (n_adv != 3 || n_done != 1 || n_both != 0) begin
            n_fail++; $display("FAIL wo_pulses: got adv=%0d done=%0d both=%0d want 3 1 0", n_adv, n_done, n_both);
        end
        n_chk++;
        if (done_cyc - start_cyc != 7) begin n_fail++; $display("FAIL wo_latency: got %0d want 7", done_cyc - start_cyc); end
        n_chk++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wo_idle: busy got %b want 0", busy_o); end
    endtask

    task automatic test_wr_stall();
        stall_pct = 0;
        wr_force = 1'b1;
        model_cmds(2'd2, 2, 16'h0010);
        start_test(2'd2, 32'd2, 8'h3C, 16'h0010);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            n_chk++;
            if (amm_write_o !== 1'b1 || amm_read_o !== 1'b0 || amm_address_o !== 16'h0010 || next_addr_en_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_stall_hold%0d: got w=%b r=%b a=%h en=%b want w=1 r=0 a=0010 en=0",
                         k, amm_write_o, amm_read_o, amm_address_o, next_addr_en_o);
            end
        end
        @(negedge clk_i);
        wr_force = 1'b0;
        wait_done(60);
        n_chk++;
        if (q_w.size() != e_w.size()) begin n_fail++; $display("FAIL wr_count: got %0d cmds want %0d", q_w.size(), e_w.size()); end
        for (int i = 0; i < q_w.size() && i < e_w.size(); i++) begin
            n_chk++;
            if (q_w[i] !== e_w[i] || q_a[i] !== e_a[i] || (e_w[i] && q_d[i] !== {(DATA_W/8){8'h3C}})) begin
                n_fail++;
                $display("FAIL wr_cmd%0d: got w=%b a=%h d=%h want w=%b a=%h", i, q_w[i], q_a[i], q_d[i], e_w[i], e_a[i]);
            end
        end
        n_chk++;
        if (n_adv != 2 || n_done != 1 || n_both != 0 || done_cyc - start_cyc != exp_latency(2'd2, 2) + 3) begin
            n_fail++;
            $display("FAIL wr_pulses: got adv=%0d done=%0d both=%0d lat=%0d want 2 1 0 %0d",
                     n_adv, n_done, n_both, done_cyc - start_cyc, exp_latency(2'd2, 2) + 3);
        end
    endtask

    task automatic test_zero();
        stall_pct = 0;
        start_test(2'd2, 32'd0, 8'h77, 16'h0100);
        wait_done(20);
        n_chk++;
        if (n_done != 1 || done_cyc - start_cyc != 1 || q_w.size() != 0 || n_adv != 0) begin
            n_fail++;
            $display("FAIL zero_count: got done=%0d lat=%0d cmds=%0d adv=%0d want 1 1 0 0",
                     n_done, done_cyc - start_cyc, q_w.size(), n_adv);
        end
    endtask

    task automatic test_busy_start();
        stall_pct = 0;
        model_cmds(2'd0, 3, 16'h0040);
        start_test(2'd0, 32'd3, 8'h5A, 16'h0040);
        @(posedge clk_i); #1;
        gen_base = 16'h0999;
        test_mode_i = 2'd1; trans_cnt_i = 32'd9; data_pattern_i = 8'hFF;
        test_start_i = 1'b1;
        @(posedge clk_i); #1;
        test_start_i = 1'b0;
        wait_done(60);
        n_chk++;
        if (q_w.size() != e_w.size()) begin n_fail++; $display("FAIL busy_count: got %0d cmds want %0d", q_w.size(), e_w.size()); end
        for (int i = 0; i < q_w.size() && i < e_w.size(); i++) begin
            n_chk++;
            if (q_w[i] !== e_w[i] || q_a[i] !== e_a[i] || q_d[i] !== {(DATA_W/8){8'h5A}}) begin
                n_fail++;
                $display("FAIL busy_cmd%0d: got w=%b a=%h d=%h want w=%b a=%h", i, q_w[i], q_a[i], q_d[i], e_w[i], e_a[i]);
            end
        end
        n_chk++;
        if (n_adv != 3 || n_done != 1 || done_cyc - start_cyc != 7) begin
            n_fail++; $display("FAIL busy_pulses: got adv=%0d done=%0d lat=%0d want 3 1 7", n_adv, n_done, done_cyc - start_cyc);
        end
    endtask

    task automatic test_reset_mid();
        stall_pct = 0;
        wr_force = 1'b1;
        start_test(2'd1, 32'd3, 8'hC3, 16'h0020);
        @(posedge clk_i); #1;
        n_chk++;
        if (amm_read_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_read: got %b want 1", amm_read_o); end
        #2 rst_i = 1'b1;
        #1;
        n_chk++;
        if ({next_addr_en_o, amm_address_o, amm_write_o, amm_read_o, amm_writedata_o, busy_o, done_o} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got en=%b a=%h w=%b r=%b d=%h busy=%b done=%b, want all 0",
                     next_addr_en_o, amm_address_o, amm_write_o, amm_read_o, amm_writedata_o, busy_o, done_o);
        end
        @(negedge clk_i);
        wr_force = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_chk++;
        if (n_done != 0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_nodone: got done=%0d busy=%b want 0 0", n_done, busy_o); end
        model_cmds(2'd0, 2, 16'h0030);
        start_test(2'd0, 32'd2, 8'h11, 16'h0030);
        wait_done(60);
        n_chk++;
        if (q_w.size() != e_w.size() || n_adv != 2 || n_done != 1 || done_cyc - start_cyc != 5) begin
            n_fail++;
            $display("FAIL rstmid_rerun: got cmds=%0d adv=%0d done=%0d lat=%0d want %0d 2 1 5",
                     q_w.size(), n_adv, n_done, done_cyc - start_cyc, e_w.size());
        end
        for (int i = 0; i < q_w.size() && i < e_w.size(); i++) begin
            n_chk++;
            if (q_w[i] !== e_w[i] || q_a[i] !== e_a[i] || q_d[i] !== {(DATA_W/8){8'h11}}) begin
                n_fail++;
                $display("FAIL rstmid_cmd%0d: got w=%b a=%h d=%h want w=%b a=%h", i, q_w[i], q_a[i], q_d[i], e_w[i], e_a[i]);
            end
        end
    endtask

    task automatic test_reserved();
        stall_pct = 0;
        start_test(2'd3, 32'd1, 8'h00, 16'h0077);
        wait_done(20);
        n_chk++;
        if (q_w.size() != 1 || n_done != 1 || n_adv != 1) begin
            n_fail++; $display("FAIL rsv_count: got cmds=%0d done=%0d adv=%0d want 1 1 1", q_w.size(), n_done, n_adv);
        end else begin
            n_chk++;
            if (q_w[0] !== 1'b0 || q_a[0] !== 16'h0077) begin
                n_fail++; $display("FAIL rsv_cmd: got w=%b a=%h want w=0 a=0077", q_w[0], q_a[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]        m;
        int unsigned       n;
        logic [7:0]        p;
        logic [ADDR_W-1:0] b;
        for (int it = 0; it < 10; it++) begin
            m = 2'($urandom_range(0, 3));
            n = $urandom_range(0, 6);
            p = 8'($urandom);
            b = ADDR_W'($urandom);
            stall_pct = (it % 3 == 0) ? 0 : int'($urandom_range(10, 60));
            model_cmds(m, n, b);
            start_test(m, n, p, b);
            wait_done(1500);
            stall_pct = 0;
            n_chk++;
            if (q_w.size() != e_w.size() || n_adv != int'(n) || n_done != 1 || n_both != 0) begin
                n_fail++;
                $display("FAIL rand%0d_summary: m=%0d n=%0d got cmds=%0d adv=%0d done=%0d both=%0d want %0d %0d 1 0",
                         it, m, n, q_w.size(), n_adv, n_done, n_both, e_w.size(), n);
            end
            for (int i = 0; i < q_w.size() && i < e_w.size(); i++) begin
                n_chk++;
                if (q_w[i] !== e_w[i] || q_a[i] !== e_a[i] || q_d[i] !== {(DATA_W/8){p}}) begin
                    n_fail++;
                    $display("FAIL rand%0d_cmd%0d: got w=%b a=%h d=%h want w=%b a=%h d=%h",
                             it, i, q_w[i], q_a[i], q_d[i], e_w[i], e_a[i], {(DATA_W/8){p}});
                end
            end
            if (it % 3 == 0) begin
                n_chk++;
                if (done_cyc - start_cyc != exp_latency(m, n)) begin
                    n_fail++;
                    $display("FAIL rand%0d_latency: got %0d want %0d", it, done_cyc - start_cyc, exp_latency(m, n));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_wr_stall();
        test_zero();
        test_busy_start();
        test_reset_mid();
        test_reserved();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
